// File: rtl/keypad_debouncer.sv
// ---------------------------------------------------------------------------
// keypad_debouncer
//
// Purpose:
//   Sits between the keypad column scanner and the digit-history / display
//   logic. It synchronises the raw keypad row lines, detects a press on the
//   column currently being driven, and debounces both press and release. It
//   emits a 4-bit key code together with a one-cycle valid strobe. While a key
//   is down it raises button_pressed so the scanner holds its column.
//
// Ports:
//   clk             in   1  system clock
//   reset           in   1  asynchronous, active-high reset
//   rows_async      in   4  raw keypad rows, active-high, not synchronised
//   col_keys        in   4  one-hot column currently driven by the scanner
//   button_pressed  out  1  high in DEBOUNCE, HELD and RELEASE states
//   key_code        out  4  code of the last accepted key, held until the next
//   key_valid       out  1  one-cycle strobe in the cycle key_code updates
//
// Output strobe semantics:
//   key_valid has no back-pressure. It is high for exactly one clk cycle, and
//   key_code already carries the new value in that cycle. The consumer must
//   sample key_code whenever key_valid is high.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles required for press and for release (>=2)
//   CNT_W            debounce counter width; must hold DEBOUNCE_CYCLES-1
// ---------------------------------------------------------------------------
module keypad_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_async,
  input  logic [3:0] col_keys,
  output logic       button_pressed,
  output logic [3:0] key_code,
  output logic       key_valid
);

  // Terminal count of the debounce counter. The counter is cleared on every
  // state entry and never counts past this value, so it cannot wrap.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Registered state
  // -------------------------------------------------------------------------
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       row_lat;   // index of the row being debounced
  logic [3:0]       col_lat;   // one-hot column captured at press time
  logic [3:0]       sync_q1;   // first synchroniser stage
  logic [3:0]       row_sync;  // second synchroniser stage, seen by the FSM

  // -------------------------------------------------------------------------
  // Next-state signals
  // -------------------------------------------------------------------------
  state_t           state_next;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       row_lat_next;
  logic [3:0]       col_lat_next;
  logic [3:0]       key_code_next;
  logic             key_valid_next;

  // -------------------------------------------------------------------------
  // Helper decodes
  // -------------------------------------------------------------------------
  logic       col_one_hot;
  logic [1:0] row_first;
  logic [1:0] col_idx;
  logic       row_hit;
  logic       cnt_done;
  logic [3:0] decoded;

  // Two-flop synchroniser for the asynchronous row lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1  <= 4'b0000;
      row_sync <= 4'b0000;
    end else begin
      sync_q1  <= rows_async;
      row_sync <= sync_q1;
    end
  end

  // A column vector is one-hot when it is non-zero and clearing its lowest set
  // bit leaves zero.
  assign col_one_hot = (col_keys != 4'b0000) &&
                       ((col_keys & (col_keys - 4'd1)) == 4'b0000);

  // When several rows are active at once, the lowest row index wins.
  always_comb begin
    row_first = 2'd0;
    if (row_sync[0])      row_first = 2'd0;
    else if (row_sync[1]) row_first = 2'd1;
    else if (row_sync[2]) row_first = 2'd2;
    else if (row_sync[3]) row_first = 2'd3;
  end

  // col_lat is one-hot by construction, so a simple encoder is enough.
  always_comb begin
    col_idx = 2'd0;
    if (col_lat[0])      col_idx = 2'd0;
    else if (col_lat[1]) col_idx = 2'd1;
    else if (col_lat[2]) col_idx = 2'd2;
    else if (col_lat[3]) col_idx = 2'd3;
  end

  // After the press is latched, only the latched row bit matters.
  assign row_hit  = row_sync[row_lat];
  assign cnt_done = (cnt == CNT_MAX);

  // Keypad legend: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C,
  // row3 = E 0 F D (columns 0..3).
  always_comb begin
    decoded = 4'h0;
    case ({row_lat, col_idx})
      4'b00_00: decoded = 4'h1;
      4'b00_01: decoded = 4'h2;
      4'b00_10: decoded = 4'h3;
      4'b00_11: decoded = 4'hA;
      4'b01_00: decoded = 4'h4;
      4'b01_01: decoded = 4'h5;
      4'b01_10: decoded = 4'h6;
      4'b01_11: decoded = 4'hB;
      4'b10_00: decoded = 4'h7;
      4'b10_01: decoded = 4'h8;
      4'b10_10: decoded = 4'h9;
      4'b10_11: decoded = 4'hC;
      4'b11_00: decoded = 4'hE;
      4'b11_01: decoded = 4'h0;
      4'b11_10: decoded = 4'hF;
      4'b11_11: decoded = 4'hD;
      default:  decoded = 4'h0;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM state and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      row_lat   <= 2'd0;
      col_lat   <= 4'b0000;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      row_lat   <= row_lat_next;
      col_lat   <= col_lat_next;
      key_code  <= key_code_next;
      key_valid <= key_valid_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    row_lat_next   = row_lat;
    col_lat_next   = col_lat;
    key_code_next  = key_code;
    key_valid_next = 1'b0;

    case (state)
      IDLE: begin
        // Ignore rows unless the scanner is driving exactly one column;
        // otherwise the key position would be ambiguous.
        if ((row_sync != 4'b0000) && col_one_hot) begin
          row_lat_next = row_first;
          col_lat_next = col_keys;
          cnt_next     = '0;
          state_next   = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (!row_hit) begin
          // The row dropped before it was stable long enough: treat it as a
          // glitch and report nothing.
          cnt_next   = '0;
          state_next = IDLE;
        end else if (cnt_done) begin
          cnt_next       = '0;
          state_next     = HELD;
          key_code_next  = decoded;
          key_valid_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      HELD: begin
        // No auto-repeat: stay here quietly while the key is held down.
        if (!row_hit) begin
          cnt_next   = '0;
          state_next = RELEASE;
        end
      end

      RELEASE: begin
        if (row_hit) begin
          // Contact bounce during release. Go back to HELD without
          // re-announcing the key.
          cnt_next   = '0;
          state_next = HELD;
        end else if (cnt_done) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Decoded straight from the registered state, so reset clears it at once.
  assign button_pressed = (state != IDLE);

endmodule

// File: tb/tb_keypad_debouncer.sv
// ---------------------------------------------------------------------------
// tb_keypad_debouncer
//
// Directed bench for keypad_debouncer with DEBOUNCE_CYCLES = 4. Inputs change
// 1 time unit after a rising edge. Outputs are sampled at the same point.
// "Edge n" below means the n-th rising edge after the stimulus was applied.
// ---------------------------------------------------------------------------
module tb_keypad_debouncer;

  logic       clk;
  logic       reset;
  logic [3:0] rows_async;
  logic [3:0] col_keys;
  logic       button_pressed;
  logic [3:0] key_code;
  logic       key_valid;

  int errors = 0;
  int checks = 0;
  int pulses = 0;   // key_valid cycles observed by tick()

  keypad_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rows_async    (rows_async),
    .col_keys      (col_keys),
    .button_pressed(button_pressed),
    .key_code      (key_code),
    .key_valid     (key_valid)
  );

  // -------------------------------------------------------------------------
  // Clock and reset
  // -------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and leave the bench 1 unit past the last edge.
  // Each cycle in which key_valid is high adds one to pulses.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (key_valid === 1'b1) pulses++;
    end
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset      = 1'b1;
    rows_async = 4'b0000;
    col_keys   = 4'b0000;
    #2;
    tick(2);
    checks++;
    if (button_pressed !== 1'b0) begin
      errors++; $display("FAIL reset_bp: got %b expected 0", button_pressed);
    end
    checks++;
    if (key_code !== 4'h0) begin
      errors++; $display("FAIL reset_code: got %h expected 0", key_code);
    end
    checks++;
    if (key_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", key_valid);
    end
    reset = 1'b0;
    tick(3);
    checks++;
    if (button_pressed !== 1'b0) begin
      errors++; $display("FAIL reset_idle_bp: got %b expected 0", button_pressed);
    end
  endtask

  task automatic test_clean_press();
    pulses     = 0;
    col_keys   = 4'b0010;
    rows_async = 4'b0001;
    for (int e = 1; e <= 20; e++) begin
      tick(1);
      if (e == 2) begin
        checks++;
        if (button_pressed !== 1'b0) begin
          errors++; $display("FAIL clean_bp_e2: got %b expected 0", button_pressed);
        end
      end
      if (e == 3) begin
        checks++;
        if (button_pressed !== 1'b1) begin
          errors++; $display("FAIL clean_bp_e3: got %b expected 1", button_pressed);
        end
      end
      if (e == 6) begin
        checks++;
        if (key_valid !== 1'b0) begin
          errors++; $display("FAIL clean_kv_e6: got %b expected 0", key_valid);
        end
      end
      if (e == 7) begin
        checks++;
        if (key_valid !== 1'b1) begin
          errors++; $display("FAIL clean_kv_e7: got %b expected 1", key_valid);
        end
        checks++;
        if (key_code !== 4'h2) begin
          errors++; $display("FAIL clean_code: got %h expected 2", key_code);
        end
      end
      if (e == 8) begin
        checks++;
        if (key_valid !== 1'b0) begin
          errors++; $display("FAIL clean_kv_e8: got %b expected 0", key_valid);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL clean_pulses: got %0d expected 1", pulses);
    end
    // Release: RELEASE is entered at edge 3 and IDLE is reached at edge 7.
    rows_async = 4'b0000;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      if (e == 6) begin
        checks++;
        if (button_pressed !== 1'b1) begin
          errors++; $display("FAIL clean_rel_bp_e6: got %b expected 1", button_pressed);
        end
      end
      if (e == 7) begin
        checks++;
        if (button_pressed !== 1'b0) begin
          errors++; $display("FAIL clean_rel_bp_e7: got %b expected 0", button_pressed);
        end
      end
    end
  endtask

  task automatic test_glitch();
    pulses     = 0;
    col_keys   = 4'b1000;
    rows_async = 4'b0100;
    tick(3);
    checks++;
    if (button_pressed !== 1'b1) begin
      errors++; $display("FAIL glitch_bp_e3: got %b expected 1", button_pressed);
    end
    rows_async = 4'b0000;
    tick(3);
    checks++;
    if (button_pressed !== 1'b0) begin
      errors++; $display("FAIL glitch_bp_e6: got %b expected 0", button_pressed);
    end
    tick(6);
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL glitch_pulses: got %0d expected 0", pulses);
    end
    checks++;
    if (key_code !== 4'h2) begin
      errors++; $display("FAIL glitch_code: got %h expected 2", key_code);
    end
  endtask

  task automatic test_release_bounce();
    logic bp_dropped;
    pulses     = 0;
    bp_dropped = 1'b0;
    col_keys   = 4'b0010;
    rows_async = 4'b1000;
    tick(7);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h0) begin
      errors++;
      $display("FAIL bounce_accept: got valid=%b code=%h expected valid=1 code=0",
               key_valid, key_code);
    end
    tick(3);
    for (int k = 0; k < 3; k++) begin
      rows_async = 4'b0000;
      tick(1); if (button_pressed !== 1'b1) bp_dropped = 1'b1;
      tick(1); if (button_pressed !== 1'b1) bp_dropped = 1'b1;
      rows_async = 4'b1000;
      tick(1); if (button_pressed !== 1'b1) bp_dropped = 1'b1;
    end
    checks++;
    if (bp_dropped !== 1'b0) begin
      errors++; $display("FAIL bounce_bp_held: got dropped=%b expected 0", bp_dropped);
    end
    rows_async = 4'b0000;
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      if (e == 6) begin
        checks++;
        if (button_pressed !== 1'b1) begin
          errors++; $display("FAIL bounce_bp_e6: got %b expected 1", button_pressed);
        end
      end
      if (e == 7) begin
        checks++;
        if (button_pressed !== 1'b0) begin
          errors++; $display("FAIL bounce_bp_e7: got %b expected 0", button_pressed);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL bounce_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_two_rows();
    pulses     = 0;
    col_keys   = 4'b0001;
    rows_async = 4'b1010;
    tick(7);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h4) begin
      errors++;
      $display("FAIL two_rows_accept: got valid=%b code=%h expected valid=1 code=4",
               key_valid, key_code);
    end
    tick(10);
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL two_rows_pulses: got %0d expected 1", pulses);
    end
    // Release row 1 only. Row 3 is picked up as a new press once IDLE is
    // reached at edge 7, and it is accepted at edge 12.
    rows_async = 4'b1000;
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      if (e == 7) begin
        checks++;
        if (button_pressed !== 1'b0) begin
          errors++; $display("FAIL two_rows_idle_e7: got %b expected 0", button_pressed);
        end
      end
      if (e == 11) begin
        checks++;
        if (pulses != 1) begin
          errors++; $display("FAIL two_rows_ignored: got %0d pulses expected 1", pulses);
        end
      end
      if (e == 12) begin
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'hE) begin
          errors++;
          $display("FAIL two_rows_second: got valid=%b code=%h expected valid=1 code=e",
                   key_valid, key_code);
        end
      end
    end
    rows_async = 4'b0000;
    tick(10);
    checks++;
    if (button_pressed !== 1'b0) begin
      errors++; $display("FAIL two_rows_final_idle: got %b expected 0", button_pressed);
    end
  endtask

  task automatic test_bad_column();
    logic bp_seen;
    pulses     = 0;
    bp_seen    = 1'b0;
    rows_async = 4'b0001;
    col_keys   = 4'b0000;
    for (int e = 0; e < 10; e++) begin
      tick(1); if (button_pressed !== 1'b0) bp_seen = 1'b1;
    end
    checks++;
    if (bp_seen !== 1'b0) begin
      errors++; $display("FAIL bad_col_zero: got bp_seen=%b expected 0", bp_seen);
    end
    bp_seen  = 1'b0;
    col_keys = 4'b0011;
    for (int e = 0; e < 10; e++) begin
      tick(1); if (button_pressed !== 1'b0) bp_seen = 1'b1;
    end
    checks++;
    if (bp_seen !== 1'b0) begin
      errors++; $display("FAIL bad_col_multi: got bp_seen=%b expected 0", bp_seen);
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL bad_col_pulses: got %0d expected 0", pulses);
    end
    rows_async = 4'b0000;
    col_keys   = 4'b0001;
    tick(3);
  endtask

  task automatic test_reset_mid_op();
    pulses     = 0;
    col_keys   = 4'b0001;
    rows_async = 4'b0001;
    tick(5);  // DEBOUNCE with cnt = 2
    reset = 1'b1;
    #1;
    checks++;
    if (button_pressed !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'h0) begin
      errors++;
      $display("FAIL rst_debounce: got bp=%b valid=%b code=%h expected 0 0 0",
               button_pressed, key_valid, key_code);
    end
    #1;
    reset = 1'b0;
    // Rows are still held. The bench treats this as a fresh press, and it must
    // be fully debounced before it is accepted.
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      if (e == 6) begin
        checks++;
        if (pulses != 0) begin
          errors++; $display("FAIL rst_no_early_valid: got %0d pulses expected 0", pulses);
        end
      end
      if (e == 7) begin
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h1) begin
          errors++;
          $display("FAIL rst_fresh_accept: got valid=%b code=%h expected valid=1 code=1",
                   key_valid, key_code);
        end
      end
    end
    // Reset while in HELD, with key_valid still high.
    reset = 1'b1;
    #1;
    checks++;
    if (button_pressed !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'h0) begin
      errors++;
      $display("FAIL rst_held: got bp=%b valid=%b code=%h expected 0 0 0",
               button_pressed, key_valid, key_code);
    end
    #1;
    reset      = 1'b0;
    pulses     = 0;
    rows_async = 4'b0000;
    tick(10);
    checks++;
    if (pulses != 0 || button_pressed !== 1'b0) begin
      errors++;
      $display("FAIL rst_release_quiet: got pulses=%0d bp=%b expected 0 0",
               pulses, button_pressed);
    end
  endtask

  // -------------------------------------------------------------------------
  // Sequence and report
  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_release_bounce();
    test_two_rows();
    test_bad_column();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
